apb_master_arbiter: RTL and testbench

- Shares one APB master port between REQ_CNT testbench or firmware requesters.
- Arbitrates with round-robin priority, decodes the address into a one-hot psel across AGENT_CNT slaves, and sequences the SETUP/ACCESS phases.
- Muxes prdata/pready/pslverr back from the selected slave and returns a per-requester response.
- Sits between the requester agents and the UART APB slave bank; its APB outputs connect directly to the bus-side signals of the APB interface.

---
 rtl/apb_master_arbiter.sv | 188 ++++++++++++++++++
 tb/tb_apb_master_arbiter.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/apb_master_arbiter.sv
// Round-robin arbiter sharing one APB master port between REQ_CNT requesters,
// with address-decoded one-hot psel, SETUP/ACCESS sequencing and a wait-state timeout.
module apb_master_arbiter #(
  parameter int REQ_CNT   = 2,
  parameter int AGENT_CNT = 2,
  parameter int DW        = 32,
  parameter int APB_AW    = 32,
  parameter int SEL_LSB   = 12,
  parameter int TIMEOUT   = 16
) (
  input  logic                    pclk,
  input  logic                    presetn,
  input  logic [REQ_CNT-1:0]      req_valid,
  input  logic [REQ_CNT-1:0]      req_write,
  input  logic [REQ_CNT*APB_AW-1:0] req_addr,
  input  logic [REQ_CNT*DW-1:0]   req_wdata,
  input  logic [REQ_CNT*4-1:0]    req_strb,
  input  logic [REQ_CNT*3-1:0]    req_prot,
  output logic [REQ_CNT-1:0]      req_ready,
  output logic [REQ_CNT-1:0]      rsp_valid,
  output logic [DW-1:0]           rsp_rdata,
  output logic                    rsp_err,
  output logic                    rsp_timeout,
  output logic [AGENT_CNT-1:0]    psel,
  output logic                    penable,
  output logic                    pwrite,
  output logic [2:0]              pprot,
  output logic [3:0]              pstrb,
  output logic [APB_AW-1:0]       paddr,
  output logic [DW-1:0]           pwdata,
  input  logic [AGENT_CNT*DW-1:0] prdata,
  input  logic [AGENT_CNT-1:0]    pready,
  input  logic [AGENT_CNT-1:0]    pslverr
);

  localparam int GW    = (REQ_CNT > 1) ? $clog2(REQ_CNT) : 1;
  localparam int AIW   = (AGENT_CNT > 1) ? $clog2(AGENT_CNT) : 1;
  // One bit wider than a slave index so that out-of-range indices decode as a miss.
  localparam int SEL_W = $clog2(AGENT_CNT + 1);
  localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_e;

  state_e            state_q, state_d;
  logic [GW-1:0]     rr_q, rr_d;
  logic [GW-1:0]     gnt_q, gnt_d;
  logic [AIW-1:0]    slv_q, slv_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              err_q, err_d;
  logic              tmo_q, tmo_d;
  logic [DW-1:0]     rdata_q, rdata_d;
  logic [APB_AW-1:0] addr_q, addr_d;
  logic [DW-1:0]     wdata_q, wdata_d;
  logic [3:0]        strb_q, strb_d;
  logic [2:0]        prot_q, prot_d;
  logic              write_q, write_d;

  logic              any_req;
  logic [GW-1:0]     gnt;
  logic [APB_AW-1:0] gnt_addr;
  logic [SEL_W-1:0]  sel_field;
  logic              dec_miss;
  logic              sel_ready;
  logic              sel_err;
  logic [DW-1:0]     sel_rdata;

  // Lowest offset from rr_q wins; the loop runs downward so that entry is written last.
  always_comb begin
    any_req = 1'b0;
    gnt     = '0;
    for (int i = REQ_CNT - 1; i >= 0; i--) begin
      if (req_valid[GW'((int'(rr_q) + i) % REQ_CNT)]) begin
        gnt     = GW'((int'(rr_q) + i) % REQ_CNT);
        any_req = 1'b1;
      end
    end
  end

  assign gnt_addr  = req_addr[gnt*APB_AW +: APB_AW];
  assign sel_field = gnt_addr[SEL_LSB +: SEL_W];
  assign dec_miss  = (int'(sel_field) >= AGENT_CNT);

  assign sel_ready = pready[slv_q];
  assign sel_err   = pslverr[slv_q];
  assign sel_rdata = prdata[slv_q*DW +: DW];

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    state_d   = state_q;
    rr_d      = rr_q;
    gnt_d     = gnt_q;
    slv_d     = slv_q;
    cnt_d     = cnt_q;
    err_d     = err_q;
    tmo_d     = tmo_q;
    rdata_d   = rdata_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    strb_d    = strb_q;
    prot_d    = prot_q;
    write_d   = write_q;
    req_ready = '0;

    case (state_q)
      IDLE: begin
        // Gated by presetn so req_ready stays low while reset is held.
        if (any_req && presetn) begin
          req_ready = REQ_CNT'(1) << gnt;
          gnt_d     = gnt;
          rr_d      = GW'((int'(gnt) + 1) % REQ_CNT);
          addr_d    = gnt_addr;
          wdata_d   = req_wdata[gnt*DW +: DW];
          strb_d    = req_strb[gnt*4 +: 4];
          prot_d    = req_prot[gnt*3 +: 3];
          write_d   = req_write[gnt];
          slv_d     = AIW'(sel_field);
          cnt_d     = '0;
          err_d     = dec_miss;
          tmo_d     = 1'b0;
          rdata_d   = '0;
          state_d   = dec_miss ? RESP : SETUP;
        end
      end
      SETUP: state_d = ACCESS;
      ACCESS: begin
        if (sel_ready) begin
          rdata_d = write_q ? '0 : sel_rdata;
          err_d   = sel_err;
          state_d = RESP;
        end else if (TIMEOUT != 0 && cnt_q == CNT_W'(TIMEOUT - 1)) begin
          err_d   = 1'b1;
          tmo_d   = 1'b1;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      RESP: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      state_q <= IDLE;
      rr_q    <= '0;
      gnt_q   <= '0;
      slv_q   <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      tmo_q   <= 1'b0;
      rdata_q <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      strb_q  <= '0;
      prot_q  <= '0;
      write_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments keep every register updating from pre-edge values.
      state_q <= state_d;
      rr_q    <= rr_d;
      gnt_q   <= gnt_d;
      slv_q   <= slv_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      tmo_q   <= tmo_d;
      rdata_q <= rdata_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      strb_q  <= strb_d;
      prot_q  <= prot_d;
      write_q <= write_d;
    end
  end

  assign psel        = (state_q == SETUP || state_q == ACCESS) ? (AGENT_CNT'(1) << slv_q) : '0;
  assign penable     = (state_q == ACCESS);
  assign pwrite      = write_q;
  assign pprot       = prot_q;
  assign pstrb       = strb_q;
  assign paddr       = addr_q;
  assign pwdata      = wdata_q;
  assign rsp_valid   = (state_q == RESP) ? (REQ_CNT'(1) << gnt_q) : '0;
  assign rsp_rdata   = rdata_q;
  assign rsp_err     = (state_q == RESP) && err_q;
  assign rsp_timeout = (state_q == RESP) && tmo_q;

endmodule

// File: tb/tb_apb_master_arbiter.sv
// Self-checking bench for apb_master_arbiter: vector table, scoreboard of
// expected responses, and hand-written round-robin and mid-transfer reset sequences.
module tb_apb_master_arbiter;

  localparam int REQ_CNT = 2, AGENT_CNT = 2, DW = 32, AW = 32;

  logic                    pclk, presetn;
  logic [REQ_CNT-1:0]      req_valid, req_write, req_ready, rsp_valid;
  logic [REQ_CNT*AW-1:0]   req_addr;
  logic [REQ_CNT*DW-1:0]   req_wdata;
  logic [REQ_CNT*4-1:0]    req_strb;
  logic [REQ_CNT*3-1:0]    req_prot;
  logic [DW-1:0]           rsp_rdata, pwdata;
  logic                    rsp_err, rsp_timeout, penable, pwrite;
  logic [AGENT_CNT-1:0]    psel, pready, pslverr;
  logic [2:0]              pprot;
  logic [3:0]              pstrb;
  logic [AW-1:0]           paddr;
  logic [AGENT_CNT*DW-1:0] prdata;

  apb_master_arbiter #(.REQ_CNT(REQ_CNT), .AGENT_CNT(AGENT_CNT), .DW(DW), .APB_AW(AW),
                       .SEL_LSB(12), .TIMEOUT(16)) dut (
    .pclk(pclk), .presetn(presetn),
    .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_strb(req_strb), .req_prot(req_prot),
    .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .rsp_timeout(rsp_timeout),
    .psel(psel), .penable(penable), .pwrite(pwrite), .pprot(pprot), .pstrb(pstrb),
    .paddr(paddr), .pwdata(pwdata), .prdata(prdata), .pready(pready), .pslverr(pslverr)
  );

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  typedef struct {
    int          req;
    logic [31:0] rdata;
    logic        err;
    logic        tmo;
  } exp_t;

  typedef struct {
    int          req;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  strb;
    logic [2:0]  prot;
    int          waits;
    logic        hang;
    logic [31:0] srdata;
    logic        serr;
    logic [1:0]  exp_psel;
    int          exp_lat;
    logic [31:0] exp_rdata;
    logic        exp_err;
    logic        exp_tmo;
  } vec_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;

  // Slave model configuration, applied to whichever slave is selected.
  int          slv_waits = 0;
  logic        slv_hang  = 1'b0;
  logic [31:0] slv_rdata = '0;
  logic        slv_err   = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic set_req(input int r, input logic wr, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [3:0] strb, input logic [2:0] prot);
    req_write[r]        = wr;
    req_addr[r*AW +: AW] = addr;
    req_wdata[r*DW +: DW] = wdata;
    req_strb[r*4 +: 4]  = strb;
    req_prot[r*3 +: 3]  = prot;
    req_valid[r]        = 1'b1;
  endtask

  // Called just after a negedge; returns with time at negedge+1 of the grant cycle.
  task automatic wait_grant(output int who);
    who = -1;
    for (int c = 0; c < 50; c++) begin
      #1;
      if (|req_ready) begin
        who = req_ready[1] ? 1 : 0;
        return;
      end
      @(negedge pclk);
    end
    check("grant_timeout", 64'd1, 64'd0);
  endtask

  task automatic drain(input int budget);
    for (int c = 0; c < budget && sb.size() != 0; c++) @(negedge pclk);
    @(negedge pclk);
    #2;
    check("scoreboard_empty", 64'(sb.size()), 64'd0);
  endtask

  // Slave responder: unselected slaves drive ready/error noise that must be ignored.
  initial begin
    int wcnt;
    int s;
    wcnt = 0;
    forever begin
      @(negedge pclk);
      for (int i = 0; i < AGENT_CNT; i++) begin
        prdata[i*DW +: DW] = 32'hDEAD_0000 | 32'(i);
        pready[i]          = 1'b1;
        pslverr[i]         = 1'b1;
      end
      if (psel != '0) begin
        s = psel[1] ? 1 : 0;
        prdata[s*DW +: DW] = slv_rdata;
        pslverr[s]         = slv_err;
        pready[s]          = 1'b0;
        if (penable && !slv_hang) begin
          if (wcnt == slv_waits) pready[s] = 1'b1;
          else wcnt++;
        end
      end else begin
        wcnt = 0;
      end
    end
  end

  // Response monitor: pops the scoreboard on every completion.
  initial begin
    exp_t e;
    forever begin
      @(negedge pclk);
      #1;
      if (presetn) begin
        check("psel_onehot0", 64'($onehot0(psel)), 64'd1);
        if (|rsp_valid) begin
          if (sb.size() == 0) begin
            check("rsp_unexpected", 64'(rsp_valid), 64'd0);
          end else begin
            e = sb.pop_front();
            check("rsp_valid_req", 64'(rsp_valid), 64'(2'b01 << e.req));
            check("rsp_rdata", 64'(rsp_rdata), 64'(e.rdata));
            check("rsp_err_tmo", 64'({rsp_err, rsp_timeout}), 64'({e.err, e.tmo}));
          end
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[6];
    int   who;
    int   lat;

    vecs[0] = '{0, 1'b1, 32'h0000_1004, 32'hA5A5_0001, 4'hF, 3'd0, 0, 1'b0, 32'h0,
                1'b0, 2'b10, 3, 32'h0, 1'b0, 1'b0};
    vecs[1] = '{0, 1'b0, 32'h0000_0008, 32'h0, 4'h0, 3'd2, 3, 1'b0, 32'h0000_00C3,
                1'b0, 2'b01, 6, 32'h0000_00C3, 1'b0, 1'b0};
    vecs[2] = '{1, 1'b1, 32'h0000_2000, 32'h1111_2222, 4'h3, 3'd1, 0, 1'b0, 32'h0,
                1'b0, 2'b00, 1, 32'h0, 1'b1, 1'b0};
    vecs[3] = '{0, 1'b0, 32'h0000_0010, 32'h0, 4'h0, 3'd0, 0, 1'b1, 32'h5555_AAAA,
                1'b0, 2'b01, 18, 32'h0, 1'b1, 1'b1};
    vecs[4] = '{1, 1'b1, 32'h0000_1000, 32'hCAFE_F00D, 4'hC, 3'd4, 1, 1'b0, 32'h0,
                1'b1, 2'b10, 4, 32'h0, 1'b1, 1'b0};
    vecs[5] = '{1, 1'b0, 32'h0000_1FFC, 32'h0, 4'h0, 3'd7, 0, 1'b0, 32'h1234_5678,
                1'b0, 2'b10, 3, 32'h1234_5678, 1'b0, 1'b0};

    presetn   = 1'b0;
    req_valid = 2'b11;
    req_write = '0;
    req_addr  = '0;
    req_wdata = '0;
    req_strb  = '0;
    req_prot  = '0;
    prdata    = '0;
    pready    = '0;
    pslverr   = '0;

    // Reset state with requests pending: every output must be zero.
    repeat (2) @(negedge pclk);
    #1;
    check("reset_ctrl", 64'({psel, penable, pwrite, pprot, pstrb, req_ready, rsp_valid,
                            rsp_err, rsp_timeout}), 64'd0);
    check("reset_paddr", 64'(paddr), 64'd0);
    check("reset_data", 64'({pwdata, rsp_rdata}), 64'd0);
    req_valid = '0;
    @(negedge pclk);
    presetn = 1'b1;
    @(negedge pclk);

    // Both requesters held high: grants alternate starting at req0.
    slv_waits = 0; slv_hang = 1'b0; slv_err = 1'b0; slv_rdata = 32'hC0DE_0000;
    set_req(0, 1'b0, 32'h0000_0000, 32'h0, 4'h0, 3'd0);
    set_req(1, 1'b0, 32'h0000_1000, 32'h0, 4'h0, 3'd0);
    for (int n = 0; n < 4; n++) begin
      wait_grant(who);
      check("rr_grant", 64'(who), 64'(n % 2));
      if (who >= 0) sb.push_back('{n % 2, 32'hC0DE_0000, 1'b0, 1'b0});
      @(negedge pclk);
    end
    req_valid = '0;
    drain(20);

    // Vector table.
    for (int v = 0; v < 6; v++) begin
      slv_waits = vecs[v].waits;
      slv_hang  = vecs[v].hang;
      slv_rdata = vecs[v].srdata;
      slv_err   = vecs[v].serr;
      set_req(vecs[v].req, vecs[v].wr, vecs[v].addr, vecs[v].wdata, vecs[v].strb, vecs[v].prot);
      wait_grant(who);
      check("vec_grant", 64'(who), 64'(vecs[v].req));
      sb.push_back('{vecs[v].req, vecs[v].exp_rdata, vecs[v].exp_err, vecs[v].exp_tmo});
      lat = 999;
      for (int k = 1; k <= 60; k++) begin
        @(negedge pclk);
        #1;
        if (k == 1) begin
          req_valid = '0;
          check("vec_psel", 64'(psel), 64'(vecs[v].exp_psel));
          check("vec_setup_penable", 64'(penable), 64'd0);
          if (vecs[v].exp_psel != 2'b00) begin
            check("vec_paddr", 64'(paddr), 64'(vecs[v].addr));
            check("vec_payload", 64'({pwdata, pwrite, pstrb, pprot}),
                  64'({vecs[v].wdata, vecs[v].wr, vecs[v].strb, vecs[v].prot}));
          end
        end
        if (k == 2 && vecs[v].exp_lat > 2) check("vec_access_penable", 64'(penable), 64'd1);
        if (|rsp_valid) begin
          lat = k;
          break;
        end
      end
      check("vec_latency", 64'(lat), 64'(vecs[v].exp_lat));
      @(negedge pclk);
    end
    drain(5);

    // Reset during ACCESS aborts silently; first grant afterwards goes to req0.
    slv_waits = 0; slv_hang = 1'b1; slv_err = 1'b0; slv_rdata = 32'h7777_0001;
    set_req(1, 1'b0, 32'h0000_0040, 32'h0, 4'h0, 3'd0);
    wait_grant(who);
    repeat (3) @(negedge pclk);
    req_valid = '0;
    #1;
    check("abort_in_access", 64'(penable), 64'd1);
    presetn = 1'b0;
    #1;
    check("abort_bus", 64'({psel, penable, rsp_valid}), 64'd0);
    check("abort_paddr", 64'(paddr), 64'd0);
    slv_hang = 1'b0;
    set_req(0, 1'b0, 32'h0000_0000, 32'h0, 4'h0, 3'd0);
    set_req(1, 1'b0, 32'h0000_1000, 32'h0, 4'h0, 3'd0);
    #1;
    check("abort_ready_in_reset", 64'(req_ready), 64'd0);
    repeat (2) @(negedge pclk);
    presetn = 1'b1;
    #1;
    check("post_reset_grant", 64'(req_ready), 64'(2'b01));
    sb.push_back('{0, 32'h7777_0001, 1'b0, 1'b0});
    @(negedge pclk);
    req_valid = '0;
    drain(20);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
